// File: rtl/tlul_reg_responder.sv
// tlul_reg_responder
//   Bridges a TileLink-UL device port onto a simple single-strobe register
//   interface. One transaction is in flight at a time: a request is checked
//   when it is accepted. A legal request becomes a one-cycle register access,
//   and the responder then waits for completion or timeout. An illegal request
//   is answered straight away with an error response.
//
// Ports
//   clk_i, rst_ni            clock (rising edge), synchronous active-low reset
//   a_valid_i .. a_data_i    TL-UL A channel (request), a_ready_o accept
//   d_valid_o .. d_error_o   TL-UL D channel (response), d_ready_i accept
//   req_o, we_o, addr_o,     register access strobe and its qualifiers,
//   wdata_o, be_o            driven only during the access cycle
//   rvalid_i, rdata_i, err_i register completion, read data and error
module tlul_reg_responder #(
   parameter int TL_AW         = 32,
   parameter int TL_DW         = 32,
   parameter int TL_AIW        = 8,
   parameter int TL_DIW        = 1,
   parameter int TL_DBW        = 4,
   parameter int TL_SZW        = 2,
   parameter int TimeoutCycles = 255
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              a_valid_i,
   output logic              a_ready_o,
   input  logic [2:0]        a_opcode_i,
   input  logic [2:0]        a_param_i,
   input  logic [TL_SZW-1:0] a_size_i,
   input  logic [TL_AIW-1:0] a_source_i,
   input  logic [TL_AW-1:0]  a_address_i,
   input  logic [TL_DBW-1:0] a_mask_i,
   input  logic [TL_DW-1:0]  a_data_i,
   output logic              d_valid_o,
   input  logic              d_ready_i,
   output logic [2:0]        d_opcode_o,
   output logic [2:0]        d_param_o,
   output logic [TL_SZW-1:0] d_size_o,
   output logic [TL_AIW-1:0] d_source_o,
   output logic [TL_DIW-1:0] d_sink_o,
   output logic [TL_DW-1:0]  d_data_o,
   output logic              d_error_o,
   output logic              req_o,
   output logic              we_o,
   output logic [TL_AW-1:0]  addr_o,
   output logic [TL_DW-1:0]  wdata_o,
   output logic [TL_DBW-1:0] be_o,
   input  logic              rvalid_i,
   input  logic [TL_DW-1:0]  rdata_i,
   input  logic              err_i
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} stateT;

   stateT             state;
   stateT             nextState;

   logic              aHandshake;
   logic              reqErr;
   logic              opcodeOk;
   logic              isPutIn;
   logic              sizeAlignOk;
   logic [TL_DBW-1:0] coveredMask;

   logic [2:0]        capOpcode;
   logic [TL_SZW-1:0] capSize;
   logic [TL_AIW-1:0] capSource;
   logic [TL_AW-1:0]  capAddr;
   logic [TL_DBW-1:0] capMask;
   logic [TL_DW-1:0]  capData;
   logic              capIsGet;

   logic              respError;
   logic [TL_DW-1:0]  respData;
   logic [7:0]        waitCount;
   logic              expired;

   logic              unusedParam;

   assign unusedParam = ^a_param_i;

   // The A channel is open only in IDLE, and never while reset is held. The
   // handshake term is built from the state directly so that it does not feed
   // back through a_ready_o.
   assign a_ready_o  = (state == IDLE) && rst_ni;
   assign aHandshake = a_valid_i && (state == IDLE) && rst_ni;

   assign capIsGet = (capOpcode == 3'd4);
   assign expired  = (waitCount == 8'(TimeoutCycles - 1));

   assign d_param_o = 3'd0;
   assign d_sink_o  = '0;

   // Legality check of the incoming request, evaluated in the accept cycle.
   // Sizes above a word fall into the default branch and are rejected through
   // sizeAlignOk. coveredMask is the set of byte lanes that a naturally aligned
   // access of a_size_i touches. A PutFullData must use exactly that set.
   always_comb begin
      opcodeOk    = (a_opcode_i == 3'd0) || (a_opcode_i == 3'd1) || (a_opcode_i == 3'd4);
      isPutIn     = (a_opcode_i == 3'd0) || (a_opcode_i == 3'd1);
      sizeAlignOk = 1'b0;
      coveredMask = '0;
      case (a_size_i)
         TL_SZW'(0): begin
            sizeAlignOk = 1'b1;
            coveredMask = TL_DBW'(1) << a_address_i[1:0];
         end
         TL_SZW'(1): begin
            sizeAlignOk = ~a_address_i[0];
            coveredMask = TL_DBW'(3) << {a_address_i[1], 1'b0};
         end
         TL_SZW'(2): begin
            sizeAlignOk = (a_address_i[1:0] == 2'b00);
            coveredMask = '1;
         end
         default: begin
            sizeAlignOk = 1'b0;
         end
      endcase
      reqErr = !opcodeOk || !sizeAlignOk
               || ((a_opcode_i == 3'd0) && (a_mask_i != coveredMask))
               || (isPutIn && (a_mask_i == '0));
   end

   // State register. Reset returns to IDLE and drops any transaction in flight.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Request capture, WAIT cycle counter and response payload.
   // The payload is decided at one of two points. For a rejected request it is
   // set in the accept cycle. Otherwise it is set when WAIT ends, either on
   // completion or on timeout. A completion in the expiry cycle is treated as a
   // normal completion. A Get that ends with any error returns all ones.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         capOpcode <= '0;
         capSize   <= '0;
         capSource <= '0;
         capAddr   <= '0;
         capMask   <= '0;
         capData   <= '0;
         respError <= 1'b0;
         respData  <= '0;
         waitCount <= '0;
      end else begin
         if (aHandshake) begin
            capOpcode <= a_opcode_i;
            capSize   <= a_size_i;
            capSource <= a_source_i;
            capAddr   <= a_address_i;
            capMask   <= a_mask_i;
            capData   <= a_data_i;
            respError <= reqErr;
            respData  <= ((a_opcode_i == 3'd4) && reqErr) ? '1 : '0;
         end
         if (state == WAIT) begin
            waitCount <= waitCount + 8'd1;
            if (rvalid_i) begin
               respError <= err_i;
               respData  <= capIsGet ? (err_i ? '1 : rdata_i) : '0;
            end else if (expired) begin
               respError <= 1'b1;
               respData  <= capIsGet ? '1 : '0;
            end
         end else begin
            waitCount <= '0;
         end
      end
   end

   // Next-state and output decode. Every output defaults to zero. Register
   // strobes are driven only in ACCESS, and D-channel fields only in RESP.
   always_comb begin
      nextState  = state;
      req_o      = 1'b0;
      we_o       = 1'b0;
      addr_o     = '0;
      wdata_o    = '0;
      be_o       = '0;
      d_valid_o  = 1'b0;
      d_opcode_o = 3'd0;
      d_size_o   = '0;
      d_source_o = '0;
      d_data_o   = '0;
      d_error_o  = 1'b0;
      case (state)
         IDLE: begin
            if (aHandshake) begin
               nextState = reqErr ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            req_o     = 1'b1;
            we_o      = !capIsGet;
            addr_o    = {capAddr[TL_AW-1:2], 2'b00};
            wdata_o   = capData;
            be_o      = capIsGet ? '1 : capMask;
            nextState = WAIT;
         end
         WAIT: begin
            if (rvalid_i || expired) begin
               nextState = RESP;
            end
         end
         RESP: begin
            d_valid_o  = 1'b1;
            d_opcode_o = capIsGet ? 3'd1 : 3'd0;
            d_size_o   = capSize;
            d_source_o = capSource;
            d_data_o   = respData;
            d_error_o  = respError;
            if (d_ready_i) begin
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_tlul_reg_responder.sv
// tb_tlul_reg_responder
//   Self-checking bench for tlul_reg_responder. The bench plays both the TL-UL
//   host and the register side. It predicts each response from the protocol
//   rules: request legality, byte coverage, completion or timeout, and error
//   data. It also predicts the cycle on which the response appears.
module tb_tlul_reg_responder;

   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rstN;
   logic        aValid;
   logic        aReady;
   logic [2:0]  aOpcode;
   logic [2:0]  aParam;
   logic [1:0]  aSize;
   logic [7:0]  aSource;
   logic [31:0] aAddress;
   logic [3:0]  aMask;
   logic [31:0] aData;
   logic        dValid;
   logic        dReady;
   logic [2:0]  dOpcode;
   logic [2:0]  dParam;
   logic [1:0]  dSize;
   logic [7:0]  dSource;
   logic [0:0]  dSink;
   logic [31:0] dData;
   logic        dError;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   tlul_reg_responder #(.TimeoutCycles(TIMEOUT)) dut (
      .clk_i(clk), .rst_ni(rstN),
      .a_valid_i(aValid), .a_ready_o(aReady), .a_opcode_i(aOpcode), .a_param_i(aParam),
      .a_size_i(aSize), .a_source_i(aSource), .a_address_i(aAddress), .a_mask_i(aMask),
      .a_data_i(aData),
      .d_valid_o(dValid), .d_ready_i(dReady), .d_opcode_o(dOpcode), .d_param_o(dParam),
      .d_size_o(dSize), .d_source_o(dSource), .d_sink_o(dSink), .d_data_o(dData),
      .d_error_o(dError),
      .req_o(req), .we_o(we), .addr_o(addr), .wdata_o(wdata), .be_o(be),
      .rvalid_i(rvalid), .rdata_i(rdata), .err_i(err)
   );

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed=%h expected=%h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Byte lanes touched by an access of 2**size bytes starting at addr.
   function automatic logic [3:0] coveredBytes(input logic [31:0] address, input int size);
      logic [3:0] m;
      int low;
      m   = 4'b0000;
      low = int'(address[1:0]);
      for (int b = 0; b < 4; b++) begin
         if (b >= low && b < low + (1 << size)) m[b] = 1'b1;
      end
      return m;
   endfunction

   // Protocol legality of a request.
   function automatic bit requestBad(input int op, input int size, input logic [31:0] address,
                                     input logic [3:0] mask);
      bit bad;
      bad = 1'b0;
      if (!(op == 0 || op == 1 || op == 4)) bad = 1'b1;
      if (size > 2) bad = 1'b1;
      else if (int'(address[1:0]) % (1 << size) != 0) bad = 1'b1;
      if (op == 0 && size <= 2 && mask != coveredBytes(address, size)) bad = 1'b1;
      if ((op == 0 || op == 1) && mask == 4'b0000) bad = 1'b1;
      return bad;
   endfunction

   // One complete transaction. The register side completes rvalid 'delay'
   // cycles after its earliest legal slot, or never if delay >= TIMEOUT. The
   // host then withholds d_ready for 'stall' cycles of the response.
   task automatic applyStimulus(input string name, input int op, input int size, input logic [7:0] src,
                                input logic [31:0] address, input logic [3:0] mask,
                                input logic [31:0] data, input int delay, input bit rerr,
                                input logic [31:0] rd, input int stall);
      bit          bad;
      bit          isGet;
      bit          timedOut;
      bit          expErr;
      int          respOff;
      logic [31:0] expData;
      bad      = requestBad(op, size, address, mask);
      isGet    = (op == 4);
      timedOut = !bad && (delay >= TIMEOUT);
      expErr   = bad || timedOut || (!bad && !timedOut && rerr);
      respOff  = bad ? 1 : 3 + ((delay < TIMEOUT - 1) ? delay : TIMEOUT - 1);
      expData  = isGet ? (expErr ? 32'hFFFF_FFFF : rd) : 32'h0;

      @(negedge clk);
      checkOutput({name, " a_ready_idle"}, 32'(aReady), 32'd1);
      aValid   = 1'b1;
      aOpcode  = 3'(op);
      aParam   = 3'($urandom_range(0, 7));
      aSize    = 2'(size);
      aSource  = src;
      aAddress = address;
      aMask    = mask;
      aData    = data;
      @(negedge clk);
      aValid = 1'b0;
      if (bad) begin
         checkOutput({name, " req_bad"}, 32'(req), 32'd0);
      end else begin
         checkOutput({name, " req_access"}, 32'(req), 32'd1);
         checkOutput({name, " we"}, 32'(we), isGet ? 32'd0 : 32'd1);
         checkOutput({name, " addr"}, addr, address & 32'hFFFF_FFFC);
         checkOutput({name, " be"}, 32'(be), isGet ? 32'hF : 32'(mask));
         checkOutput({name, " wdata"}, wdata, data);
         checkOutput({name, " dvalid_access"}, 32'(dValid), 32'd0);
         for (int off = 2; off < respOff; off++) begin
            @(negedge clk);
            checkOutput({name, " req_wait"}, 32'(req), 32'd0);
            checkOutput({name, " dvalid_wait"}, 32'(dValid), 32'd0);
            rvalid = (off == 2 + delay);
            err    = rerr;
            rdata  = rd;
         end
         @(negedge clk);
         rvalid = 1'b0;
         err    = 1'b0;
      end

      for (int i = 0; i <= stall; i++) begin
         checkOutput({name, " dvalid"}, 32'(dValid), 32'd1);
         checkOutput({name, " dopcode"}, 32'(dOpcode), isGet ? 32'd1 : 32'd0);
         checkOutput({name, " derror"}, 32'(dError), 32'(expErr));
         checkOutput({name, " ddata"}, dData, expData);
         checkOutput({name, " dsource"}, 32'(dSource), 32'(src));
         checkOutput({name, " dsize"}, 32'(dSize), 32'(size));
         checkOutput({name, " dparam_sink"}, 32'({dParam, dSink}), 32'd0);
         checkOutput({name, " aready_resp"}, 32'(aReady), 32'd0);
         checkOutput({name, " req_resp"}, 32'(req), 32'd0);
         if (i < stall) begin
            rvalid = 1'($urandom_range(0, 1));
            err    = 1'b1;
            rdata  = $urandom;
            @(negedge clk);
         end
      end
      rvalid = 1'b0;
      err    = 1'b0;
      dReady = 1'b1;
      @(negedge clk);
      dReady = 1'b0;
      checkOutput({name, " dvalid_done"}, 32'(dValid), 32'd0);
      checkOutput({name, " aready_done"}, 32'(aReady), 32'd1);
   endtask

   // Reset is asserted while a Get waits on the register side. No response
   // may follow, even if a completion arrives afterwards.
   task automatic resetDuringWait();
      @(negedge clk);
      aValid   = 1'b1;
      aOpcode  = 3'd4;
      aSize    = 2'd2;
      aSource  = 8'h33;
      aAddress = 32'h0000_0040;
      aMask    = 4'hF;
      @(negedge clk);
      aValid = 1'b0;
      checkOutput("rst_wait req_access", 32'(req), 32'd1);
      @(negedge clk);
      rstN = 1'b0;
      @(negedge clk);
      checkOutput("rst_wait dvalid_in_reset", 32'(dValid), 32'd0);
      checkOutput("rst_wait req_in_reset", 32'(req), 32'd0);
      checkOutput("rst_wait aready_in_reset", 32'(aReady), 32'd0);
      rstN = 1'b1;
      #1;
      checkOutput("rst_wait aready_release", 32'(aReady), 32'd1);
      rvalid = 1'b1;
      rdata  = 32'h1234_5678;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rvalid = 1'b0;
         checkOutput("rst_wait no_dvalid", 32'(dValid), 32'd0);
         checkOutput("rst_wait no_req", 32'(req), 32'd0);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int          op;
      int          size;
      int          pick;
      logic [31:0] a;
      logic [3:0]  m;
      rstN     = 1'b0;
      aValid   = 1'b0;
      aOpcode  = '0;
      aParam   = '0;
      aSize    = '0;
      aSource  = '0;
      aAddress = '0;
      aMask    = '0;
      aData    = '0;
      dReady   = 1'b0;
      rvalid   = 1'b0;
      rdata    = '0;
      err      = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("reset dvalid", 32'(dValid), 32'd0);
      checkOutput("reset req", 32'(req), 32'd0);
      checkOutput("reset aready", 32'(aReady), 32'd0);
      checkOutput("reset ddata", dData, 32'd0);
      rstN = 1'b1;
      #1;
      checkOutput("release aready", 32'(aReady), 32'd1);
      checkOutput("release dvalid", 32'(dValid), 32'd0);

      applyStimulus("get_basic", 4, 2, 8'h5A, 32'h0000_0100, 4'hF, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 0);
      applyStimulus("put_partial", 1, 0, 8'h11, 32'h0000_0203, 4'b1000, 32'h1122_3344, 0, 1'b0, 32'h0, 0);
      applyStimulus("get_misaligned", 4, 2, 8'h22, 32'h0000_0102, 4'hF, 32'h0, 0, 1'b0, 32'h0, 0);
      applyStimulus("get_timeout", 4, 2, 8'h44, 32'h0000_0200, 4'hF, 32'h0, TIMEOUT + 2, 1'b0, 32'hCAFE_F00D, 2);
      applyStimulus("get_expiry_edge", 4, 2, 8'h45, 32'h0000_0204, 4'hF, 32'h0, TIMEOUT - 1, 1'b0, 32'h0BAD_CAFE, 0);
      applyStimulus("put_full_stall", 0, 1, 8'h66, 32'h0000_0302, 4'b1100, 32'hAABB_CCDD, 1, 1'b0, 32'h0, 3);
      applyStimulus("get_regerr", 4, 2, 8'h77, 32'h0000_0010, 4'hF, 32'h0, 1, 1'b1, 32'h5555_5555, 0);
      applyStimulus("bad_opcode", 2, 2, 8'h88, 32'h0000_0020, 4'hF, 32'h0, 0, 1'b0, 32'h0, 1);
      applyStimulus("put_zero_mask", 1, 2, 8'h99, 32'h0000_0030, 4'h0, 32'h0, 0, 1'b0, 32'h0, 0);

      for (int n = 0; n < 40; n++) begin
         pick = $urandom_range(0, 9);
         if (pick < 3) op = 0;
         else if (pick < 6) op = 1;
         else if (pick < 9) op = 4;
         else op = $urandom_range(0, 7);
         size = $urandom_range(0, 3);
         a    = $urandom;
         if (size <= 2 && $urandom_range(0, 1) == 1) a = a & ~32'((1 << size) - 1);
         m = 4'($urandom_range(0, 15));
         if (op == 0 && size <= 2 && $urandom_range(0, 1) == 1) m = coveredBytes(a, size);
         applyStimulus("random", op, size, 8'($urandom), a, m, $urandom,
                       $urandom_range(0, TIMEOUT + 1), ($urandom_range(0, 3) == 0),
                       $urandom, $urandom_range(0, 2));
      end

      resetDuringWait();
      applyStimulus("get_after_reset", 4, 2, 8'h12, 32'h0000_0400, 4'hF, 32'h0, 0, 1'b0, 32'h0F0F_0F0F, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
